// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed SRAM model with a fixed-latency response
// pipeline feeding an in-order response FIFO, throttled by an outstanding-request count.
module data_mem_responder #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2,
  parameter int resp_depth_p = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_v_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_yumi_o,
  output logic        resp_v_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  input  logic        resp_yumi_i,
  output logic        exception_o
);

  localparam int cnt_w_lp     = $clog2(resp_depth_p + 1);
  localparam int ptr_w_lp     = (resp_depth_p > 1) ? $clog2(resp_depth_p) : 1;
  localparam int mem_words_lp = 1 << addr_width_p;
  localparam logic [31:0] fault_data_lp = 32'hDEAD_BEEF;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(resp_depth_p - 1)) return '0;
    return p + ptr_w_lp'(1);
  endfunction

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (addr_width_p + 2)) != '0);
  endfunction

  logic [31:0] mem [mem_words_lp];

  logic [addr_width_p-1:0] word_idx;
  logic                    fault;
  logic                    accept;
  logic                    pop;
  logic                    push;
  logic                    mem_we;
  logic [31:0]             resp_word;

  logic [cnt_w_lp-1:0]     outst_q, outst_d;
  logic                    exception_q, exception_d;
  logic [latency_p-1:0]    pipe_v_q, pipe_v_d;
  logic [latency_p-1:0]    pipe_err_q, pipe_err_d;
  logic [31:0]             pipe_data_q [latency_p];
  logic [31:0]             pipe_data_d [latency_p];
  logic [ptr_w_lp-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]     rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [resp_depth_p-1:0] fifo_err_q, fifo_err_d;
  logic [31:0]             fifo_data_q [resp_depth_p];
  logic [31:0]             fifo_data_d [resp_depth_p];

  assign word_idx = req_addr_i[addr_width_p+1:2];
  assign fault    = addr_fault(req_addr_i);
  assign pop      = resp_v_o & resp_yumi_i;
  // A pop in the same cycle frees a slot, so a full responder still sustains one request per cycle.
  assign accept   = req_v_i & reset & ((outst_q < cnt_w_lp'(resp_depth_p)) | pop);
  assign push     = pipe_v_q[latency_p-1];
  assign mem_we   = accept & req_we_i & ~fault;

  // Load data is read before this edge's write; a request is never both load and store.
  assign resp_word = fault    ? fault_data_lp :
                     req_we_i ? 32'h0         : mem[word_idx];

  always_comb begin
    outst_d     = outst_q;
    exception_d = exception_q | (accept & fault);
    if (accept && !pop)      outst_d = outst_q + cnt_w_lp'(1);
    else if (!accept && pop) outst_d = outst_q - cnt_w_lp'(1);
  end

  always_comb begin
    pipe_v_d       = '0;
    pipe_err_d     = '0;
    pipe_data_d    = pipe_data_q;
    pipe_v_d[0]    = accept;
    pipe_err_d[0]  = fault;
    pipe_data_d[0] = resp_word;
    for (int i = 1; i < latency_p; i++) begin
      pipe_v_d[i]    = pipe_v_q[i-1];
      pipe_err_d[i]  = pipe_err_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    fifo_err_d  = fifo_err_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = pipe_data_q[latency_p-1];
      fifo_err_d[wr_ptr_q]  = pipe_err_q[latency_p-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + cnt_w_lp'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outst_q     <= '0;
      exception_q <= 1'b0;
      pipe_v_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      outst_q     <= outst_d;
      exception_q <= exception_d;
      pipe_v_q    <= pipe_v_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Payload storage carries no reset; it is qualified by the control valids above.
  always_ff @(posedge clk) begin
    pipe_err_q  <= pipe_err_d;
    pipe_data_q <= pipe_data_d;
    fifo_err_q  <= fifo_err_d;
    fifo_data_q <= fifo_data_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be_i[k]) mem[word_idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
      end
    end
  end

  assign req_yumi_o  = accept;
  assign resp_v_o    = (fifo_cnt_q != '0);
  assign resp_data_o = resp_v_o ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign resp_err_o  = resp_v_o & fifo_err_q[rd_ptr_q];
  assign exception_o = exception_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: timestamped response-queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_data_mem_responder;

  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_yumi;
  logic        req_yumi_o;
  logic        resp_v_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        exception_o;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(
    .addr_width_p(AW),
    .latency_p(LAT),
    .resp_depth_p(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_v_i(req_v),
    .req_we_i(req_we),
    .req_be_i(req_be),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .req_yumi_o(req_yumi_o),
    .resp_v_o(resp_v_o),
    .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o),
    .resp_yumi_i(resp_yumi),
    .exception_o(exception_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Model: every accepted request becomes a queue entry stamped with the first cycle it may show.
  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        known;
    int          ready;
  } rsp_t;

  rsp_t        q_m[$];
  logic [31:0] mem_m [int];
  logic        exc_m = 1'b0;
  int          cyc = 0;
  logic [31:0] popped[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd1 << (AW + 2)));
  endfunction

  function automatic bit head_vis();
    return (q_m.size() > 0) && (cyc >= q_m[0].ready);
  endfunction

  function automatic bit exp_accept();
    return req_v && reset && ((q_m.size() < DEPTH) || (head_vis() && resp_yumi));
  endfunction

  always @(posedge clk or negedge reset) begin : model_upd
    rsp_t        r;
    bit          acc;
    bit          pp;
    int          idx;
    logic [31:0] mask;
    logic [31:0] old;
    if (!reset) begin
      q_m.delete();
      exc_m = 1'b0;
    end else begin
      acc = exp_accept();
      pp  = head_vis() && resp_yumi;
      if (pp) void'(q_m.pop_front());
      if (acc) begin
        idx     = int'(req_addr[AW+1:2]);
        r.ready = cyc + 1 + LAT;
        r.known = 1'b1;
        r.err   = 1'b0;
        r.data  = 32'h0;
        if (is_fault(req_addr)) begin
          r.data = 32'hDEAD_BEEF;
          r.err  = 1'b1;
          exc_m  = 1'b1;
        end else if (req_we) begin
          old  = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
          mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
          mem_m[idx] = (old & ~mask) | (req_wdata & mask);
        end else begin
          r.known = (mem_m.exists(idx) != 0);
          if (r.known) r.data = mem_m[idx];
        end
        q_m.push_back(r);
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    ev = head_vis();
    ed = ev ? q_m[0].data : 32'h0;
    ee = ev ? q_m[0].err : 1'b0;
    check("req_yumi_o", 32'(req_yumi_o), 32'(exp_accept()));
    check("resp_v_o", 32'(resp_v_o), 32'(ev));
    if (!ev || q_m[0].known) check("resp_data_o", resp_data_o, ed);
    check("resp_err_o", 32'(resp_err_o), 32'(ee));
    check("exception_o", 32'(exception_o), 32'(exc_m));
    if (resp_v_o && resp_yumi) popped.push_back(resp_data_o);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd);
    int n;
    n         = 0;
    req_v     = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    while (!req_yumi_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_yumi_o) timeout_fail("req_accept");
    @(posedge clk);
    #1;
    req_v = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic e, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_v_o && k < 40);
    if (!resp_v_o) timeout_fail("resp_wait");
    d = resp_data_o;
    e = resp_err_o;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] d;
    logic        e;
    int          k;
    int          acc;
    int          nxt;
    reset     = 1'b0;
    req_v     = 1'b1;
    req_we    = 1'b0;
    req_be    = 4'hF;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    resp_yumi = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_yumi", 32'(req_yumi_o), 32'd0);
    check("reset_v", 32'(resp_v_o), 32'd0);
    check("reset_exc", 32'(exception_o), 32'd0);
    reset = 1'b1;
    req_v = 1'b0;
    idle(1);

    // full-word store, then load with latency measurement
    do_req(1'b1, 4'hF, 32'h10, 32'h1234_5678);
    wait_resp(d, e, k);
    check("store_resp_data", d, 32'h0);
    check("store_resp_err", 32'(e), 32'd0);
    idle(2);
    do_req(1'b0, 4'hF, 32'h10, 32'h0);
    wait_resp(d, e, k);
    check("load_latency", 32'(k), 32'(LAT + 1));
    check("load_data", d, 32'h1234_5678);
    check("load_err", 32'(e), 32'd0);
    idle(2);

    // byte-enabled store followed immediately by a load of the same word
    do_req(1'b1, 4'b0010, 32'h10, 32'hFFFF_AAFF);
    do_req(1'b0, 4'hF, 32'h10, 32'h0);
    wait_resp(d, e, k);
    check("bstore_resp_data", d, 32'h0);
    wait_resp(d, e, k);
    check("bload_data", d, 32'h1234_AA78);
    idle(2);

    // faulting requests
    do_req(1'b0, 4'hF, 32'h3, 32'h0);
    wait_resp(d, e, k);
    check("mis_data", d, 32'hDEAD_BEEF);
    check("mis_err", 32'(e), 32'd1);
    check("mis_exc", 32'(exception_o), 32'd1);
    do_req(1'b0, 4'hF, 32'h1 << (AW + 2), 32'h0);
    wait_resp(d, e, k);
    check("oor_data", d, 32'hDEAD_BEEF);
    check("oor_err", 32'(e), 32'd1);
    do_req(1'b1, 4'hF, 32'h13, 32'h0);
    wait_resp(d, e, k);
    check("fstore_err", 32'(e), 32'd1);
    do_req(1'b0, 4'hF, 32'h10, 32'h0);
    wait_resp(d, e, k);
    check("reread_data", d, 32'h1234_AA78);
    check("reread_err", 32'(e), 32'd0);
    check("exc_sticky", 32'(exception_o), 32'd1);
    idle(2);

    // prefill a block of words
    for (int i = 0; i < 12; i++) do_req(1'b1, 4'hF, 32'h100 + 32'(4 * i), 32'hA0A0_0000 + 32'(i));
    idle(6);

    // backpressure: consumer stalled, requester always asking
    popped.delete();
    resp_yumi = 1'b0;
    acc = 0;
    nxt = 0;
    for (int c = 0; c < 10; c++) begin
      req_v    = 1'b1;
      req_we   = 1'b0;
      req_addr = 32'h100 + 32'(4 * nxt);
      @(negedge clk);
      if (req_yumi_o) begin
        acc++;
        nxt++;
      end
      @(posedge clk);
      #1;
    end
    check("stall_accepts", 32'(acc), 32'(DEPTH));
    resp_yumi = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_v    = 1'b1;
      req_addr = 32'h100 + 32'(4 * nxt);
      @(negedge clk);
      if (req_yumi_o) begin
        acc++;
        nxt++;
      end
      @(posedge clk);
      #1;
    end
    check("release_accepts", 32'(acc), 32'd6);
    req_v = 1'b0;
    idle(10);
    check("stall_count", 32'(popped.size()), 32'd10);
    for (int j = 0; j < 10; j++) check("stall_order", popped[j], 32'hA0A0_0000 + 32'(j));

    // back-to-back loads with the consumer always ready
    popped.delete();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      req_v    = 1'b1;
      req_we   = 1'b0;
      req_addr = 32'h100 + 32'(4 * c);
      @(negedge clk);
      if (req_yumi_o) acc++;
      @(posedge clk);
      #1;
    end
    req_v = 1'b0;
    check("stream_accepts", 32'(acc), 32'd12);
    idle(8);
    check("stream_count", 32'(popped.size()), 32'd12);
    for (int j = 0; j < 12; j++) check("stream_order", popped[j], 32'hA0A0_0000 + 32'(j));

    // reset with three requests outstanding
    resp_yumi = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_v    = 1'b1;
      req_we   = 1'b0;
      req_addr = 32'h100 + 32'(4 * c);
      @(posedge clk);
      #1;
    end
    req_v = 1'b0;
    idle(3);
    check("pre_reset_v", 32'(resp_v_o), 32'd1);
    #2;
    reset = 1'b0;
    req_v = 1'b1;
    #1;
    check("rst_v", 32'(resp_v_o), 32'd0);
    check("rst_data", resp_data_o, 32'h0);
    check("rst_err", 32'(resp_err_o), 32'd0);
    check("rst_exc", 32'(exception_o), 32'd0);
    check("rst_yumi", 32'(req_yumi_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    req_v     = 1'b0;
    resp_yumi = 1'b1;
    popped.delete();
    do_req(1'b0, 4'hF, 32'h10, 32'h0);
    wait_resp(d, e, k);
    check("post_rst_data", d, 32'h1234_AA78);
    idle(6);
    check("no_stale", 32'(popped.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory port. It accepts load/store requests issued by the core on its to-memory channel and performs them on an internal word-addressed SRAM model. It returns one response per request, in order, on the core's from-memory channel after a fixed, parameterised latency. It sits beside each core in the tile, and the bench uses it as the data memory behind the core.

## Interface
- addr_width_p, 10: word-address bits; memory holds 2**addr_width_p 32-bit words
- latency_p, 2: cycles from request acceptance to earliest response valid; legal 1..4
- resp_depth_p, 4: maximum outstanding requests (in flight + queued); must be ≥ latency_p+1

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all control state immediately
- req_v_i  in  1  request valid from core
- req_we_i  in  1  1 = store, 0 = load
- req_be_i  in  4  byte enables for stores, bit k = byte k (little-endian)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data
- req_yumi_o  out  1  request accepted this cycle (combinational)
- resp_v_o  out  1  response valid
- resp_data_o  out  32  load data; 0 for stores
- resp_err_o  out  1  response corresponds to a faulting request
- resp_yumi_i  in  1  core consumes response this cycle; legal only when resp_v_o=1
- exception_o  out  1  sticky fault flag

## Operation
- Word index = req_addr_i[addr_width_p+1:2].
- Fault: req_addr_i[1:0]≠0, or any of req_addr_i[31:addr_width_p+2] nonzero.
- Acceptance: req_yumi_o = req_v_i & reset & (outstanding < resp_depth_p | resp_v_o & resp_yumi_i).
- Access happens in the accept cycle:
  - Store writes the enabled bytes at the rising edge.
  - Load reads the array before that edge's writes, so a load accepted the cycle after a store sees the stored data.
- Faulting request:
  - No array write.
  - Response data 32'hDEAD_BEEF, resp_err_o=1.
  - exception_o sets and holds until reset.
- Every accepted request, store or load, produces exactly one response. Responses return in acceptance order.
- Each accepted request enters a latency_p-stage valid/data/err shift pipeline. The pipeline output pushes into a response FIFO of depth resp_depth_p. The FIFO head drives resp_*_o.
- outstanding counter:
  - +1 on accept, −1 on resp_yumi_i; both in one cycle leaves it unchanged.
  - Range 0..resp_depth_p, width $clog2(resp_depth_p+1).
- Because outstanding is bounded by resp_depth_p, the FIFO never overflows. A pipeline push and a head pop in the same cycle are both honoured.
- Pipeline stages always advance; backpressure acts only through acceptance.
- resp_yumi_i while resp_v_o=0 is ignored: no pop, no counter change.

## Timing
- Request accepted at edge N: response valid from cycle N+latency_p if the FIFO is empty; otherwise it follows the queued responses.
- Throughput: one request per cycle sustained while the core consumes every cycle, because resp_depth_p ≥ latency_p+1.
- Reset (async, low), applied at any time including mid-transaction:
  - outstanding=0, pipeline valids=0, FIFO pointers=0.
  - resp_v_o=0, resp_err_o=0, resp_data_o=0, exception_o=0, req_yumi_o=0.
  - In-flight requests are discarded. Memory contents are not cleared.
- Deassertion is synchronised by the caller. First acceptance is possible on the first edge with reset high.

## Test plan
- Store 32'h1234_5678, be=4'hF, addr 0x10; then load addr 0x10 → load response data 32'h1234_5678, resp_err_o=0, valid exactly latency_p cycles after acceptance.
- Store be=4'b0010 data 32'hFFFF_AAFF onto word holding 32'h1234_5678, then load → 32'h1234_AA78.
- resp_yumi_i held 0 and req_v_i held 1 for 10 cycles → exactly resp_depth_p accepts, then req_yumi_o=0. Release resp_yumi_i → responses drain in order, and one new accept occurs per pop.
- Load addr 0x3 (misaligned) and load addr 1<<(addr_width_p+2) → each response data 32'hDEAD_BEEF, resp_err_o=1, exception_o=1 and stays 1; the array is unchanged on re-read.
- Back-to-back loads every cycle with resp_yumi_i=1 every cycle → one response per cycle, no stalls, order preserved.
- reset low with 3 requests outstanding → all outputs 0 immediately. After release, a fresh load returns previously stored data with no stale responses.
